spi_cmd_trg_multi: RTL and testbench

Parametrised multi-channel SPI command trigger. Passively snoops the SPI flash bus (chip select, SCLK, MOSI) in the CLK160M domain and decodes an 8-bit opcode followed by an ADDR_W-bit address. It drives a stretched, retriggerable trigger pulse on every channel whose opcode and address window match. It also keeps a saturating hit counter per channel. It sits between the SPI pins and the logic-analyser trigger outputs, and is the next generation of the fixed five-channel trigger.

---
 rtl/spi_trg_pkg.sv | 21 ++
 rtl/spi_trg_pls_gen.sv | 48 ++++
 rtl/spi_cmd_trg_multi.sv | 148 ++++++++++++++
 tb/tb_spi_cmd_trg_multi.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_trg_pkg.sv
// Shared types and SPI flash opcode constants for the SPI command trigger.
package spi_trg_pkg;

    // Frame decoder states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        EVAL    = 2'd2,
        WAIT_CS = 2'd3
    } frame_state_e;

    // Common flash opcodes, handy when programming CH_OPCODE
    localparam logic [7:0] PRG_EXECUTE      = 8'h10;
    localparam logic [7:0] READ_STATUS1     = 8'h0F;
    localparam logic [7:0] READ_STATUS2     = 8'h05;
    localparam logic [7:0] BLOCK_ERASE_128K = 8'hD8;
    localparam logic [7:0] PAGE_DATA_READ   = 8'h13;
    localparam logic [7:0] WRITE_STATUS1    = 8'h1F;
    localparam logic [7:0] WRITE_STATUS2    = 8'h01;

endpackage

// File: rtl/spi_trg_pls_gen.sv
// One trigger channel: retriggerable stretched pulse plus saturating hit counter.
module spi_trg_pls_gen #(
    parameter int PLS_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hit_i,
    input  logic [PLS_W-1:0] pls_len_i,
    input  logic             cnt_clr_i,
    output logic             pls_o,
    output logic [CNT_W-1:0] hit_cnt_o
);

    logic [PLS_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;

    // Next-state: a hit (re)loads the pulse length, zero length is stretched to one cycle
    always_comb begin
        pcnt_d = pcnt_q;
        hcnt_d = hcnt_q;
        if (hit_i) begin
            pcnt_d = (pls_len_i == '0) ? PLS_W'(1) : pls_len_i;
        end else if (pcnt_q != '0) begin
            pcnt_d = pcnt_q - PLS_W'(1);
        end
        if (cnt_clr_i) begin
            hcnt_d = hit_i ? CNT_W'(1) : '0;
        end else if (hit_i && (hcnt_q != '1)) begin
            hcnt_d = hcnt_q + CNT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt_q <= '0;
            hcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            hcnt_q <= hcnt_d;
        end
    end

    assign pls_o     = (pcnt_q != '0);
    assign hit_cnt_o = hcnt_q;

endmodule

// File: rtl/spi_cmd_trg_multi.sv
// Multi-channel SPI command trigger: snoops the flash bus, decodes opcode + address
// and fires a stretched pulse on every channel whose opcode and address window match.
module spi_cmd_trg_multi
    import spi_trg_pkg::*;
#(
    parameter int NCH    = 5,
    parameter int ADDR_W = 24,
    parameter int PLS_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                  CLK160M,
    input  logic                  RESET,
    input  logic                  SPI_CS,
    input  logic                  SPI_CLK,
    input  logic                  SPI_MOSI,
    input  logic [NCH-1:0]        CH_EN,
    input  logic [NCH*8-1:0]      CH_OPCODE,
    input  logic [NCH*ADDR_W-1:0] CH_LOW_ADDR,
    input  logic [NCH*ADDR_W-1:0] CH_HIGH_ADDR,
    input  logic [PLS_W-1:0]      PLS_LEN,
    input  logic                  CNT_CLR,
    output logic [NCH-1:0]        TRG_PLS,
    output logic                  TRG_ANY,
    output logic [NCH*CNT_W-1:0]  HIT_CNT
);

    localparam int FRAME_W = 8 + ADDR_W;
    localparam int BCNT_W  = $clog2(FRAME_W + 1);

    logic cs_s1_q, cs_s2_q, cs_s3_q;
    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic mosi_s1_q, mosi_s2_q;

    logic sclk_rise, cs_fall, cs_high;

    frame_state_e        state_q, state_d;
    logic [FRAME_W-1:0]  sr_q, sr_d;
    logic [FRAME_W-1:0]  cmd_q, cmd_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;

    logic [7:0]          opcode;
    logic [ADDR_W-1:0]   addr;
    logic [NCH-1:0]      hit;

    // Two-flop synchronisers plus one delay flop for edge detection; CS idles high
    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_s3_q   <= 1'b1;
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            cs_s1_q   <= SPI_CS;
            cs_s2_q   <= cs_s1_q;
            cs_s3_q   <= cs_s2_q;
            sclk_s1_q <= SPI_CLK;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            mosi_s1_q <= SPI_MOSI;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    // MOSI is taken from the same stage that flags the SCLK edge
    assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
    assign cs_fall   = ~cs_s2_q & cs_s3_q;
    assign cs_high   = cs_s2_q;

    // Frame FSM next-state: capture opcode+address, evaluate once, then ignore the rest
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bcnt_d  = bcnt_q;
        cmd_d   = cmd_q;
        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = CAPTURE;
                    sr_d    = '0;
                    bcnt_d  = '0;
                end
            end
            CAPTURE: begin
                if (sclk_rise) begin
                    sr_d   = {sr_q[FRAME_W-2:0], mosi_s2_q};
                    bcnt_d = bcnt_q + BCNT_W'(1);
                    if (bcnt_q == BCNT_W'(FRAME_W - 1)) begin
                        cmd_d   = sr_d;
                        state_d = EVAL;
                    end
                end
            end
            EVAL:    state_d = WAIT_CS;
            WAIT_CS: state_d = WAIT_CS;
            default: state_d = IDLE;
        endcase
        // Deselect aborts whatever frame is in progress
        if (cs_high) begin
            state_d = IDLE;
        end
    end

    // Frame FSM, shift and command registers
    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bcnt_q  <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bcnt_q  <= bcnt_d;
            cmd_q   <= cmd_d;
        end
    end

    assign opcode = cmd_q[FRAME_W-1 -: 8];
    assign addr   = cmd_q[ADDR_W-1:0];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        // An inverted window (low > high) can never satisfy both bounds
        assign hit[i] = (state_q == EVAL) & CH_EN[i]
                      & (opcode == CH_OPCODE[8*i +: 8])
                      & (addr >= CH_LOW_ADDR[ADDR_W*i +: ADDR_W])
                      & (addr <= CH_HIGH_ADDR[ADDR_W*i +: ADDR_W]);

        spi_trg_pls_gen #(
            .PLS_W (PLS_W),
            .CNT_W (CNT_W)
        ) u_pls_gen (
            .clk_i     (CLK160M),
            .rst_i     (RESET),
            .hit_i     (hit[i]),
            .pls_len_i (PLS_LEN),
            .cnt_clr_i (CNT_CLR),
            .pls_o     (TRG_PLS[i]),
            .hit_cnt_o (HIT_CNT[CNT_W*i +: CNT_W])
        );
    end

    assign TRG_ANY = |TRG_PLS;

endmodule

// File: tb/tb_spi_cmd_trg_multi.sv
// Directed bench for spi_cmd_trg_multi: bit-banged SPI frames, pulse timing monitor,
// hand-computed expectations.
module tb_spi_cmd_trg_multi;
    import spi_trg_pkg::*;

    localparam int NCH    = 5;
    localparam int ADDR_W = 24;
    localparam int PLS_W  = 10;
    localparam int CNT_W  = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  spi_cs, spi_clk, spi_mosi;
    logic [NCH-1:0]        ch_en;
    logic [NCH*8-1:0]      ch_opcode;
    logic [NCH*ADDR_W-1:0] ch_low, ch_high;
    logic [PLS_W-1:0]      pls_len;
    logic                  cnt_clr;
    logic [NCH-1:0]        trg_pls;
    logic                  trg_any;
    logic [NCH*CNT_W-1:0]  hit_cnt;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int rise_cyc = 0;
    int first_hi [NCH];
    int last_hi  [NCH];
    int n_hi     [NCH];
    int n_any;
    logic mon_clr = 1'b1;
    int r1, r2;

    spi_cmd_trg_multi #(
        .NCH    (NCH),
        .ADDR_W (ADDR_W),
        .PLS_W  (PLS_W),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK160M      (clk),
        .RESET        (rst),
        .SPI_CS       (spi_cs),
        .SPI_CLK      (spi_clk),
        .SPI_MOSI     (spi_mosi),
        .CH_EN        (ch_en),
        .CH_OPCODE    (ch_opcode),
        .CH_LOW_ADDR  (ch_low),
        .CH_HIGH_ADDR (ch_high),
        .PLS_LEN      (pls_len),
        .CNT_CLR      (cnt_clr),
        .TRG_PLS      (trg_pls),
        .TRG_ANY      (trg_any),
        .HIT_CNT      (hit_cnt)
    );

    always #5 clk = ~clk;

    // Pulse monitor sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (mon_clr) begin
            for (int k = 0; k < NCH; k++) begin
                first_hi[k] = -1;
                last_hi[k]  = -1;
                n_hi[k]     = 0;
            end
            n_any = 0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (trg_pls[k]) begin
                    if (first_hi[k] < 0) first_hi[k] = cyc;
                    last_hi[k] = cyc;
                    n_hi[k]++;
                end
            end
            if (trg_any) n_any++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic mon_reset();
        @(negedge clk);
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        wait_neg(4);
    endtask

    task automatic cs_up();
        wait_neg(4);
        spi_cs = 1'b1;
        wait_neg(8);
    endtask

    // Send bits word[hi..lo] MSB first; optionally pulse CNT_CLR in the EVAL cycle of the last bit
    task automatic send_bits(input logic [31:0] word, input int hi, input int lo, input bit clr_at_hit);
        for (int i = hi; i >= lo; i--) begin
            spi_mosi = word[i];
            wait_neg(4);
            spi_clk  = 1'b1;
            rise_cyc = cyc;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                if (k == 3 && i == lo && clr_at_hit) cnt_clr = 1'b1;
                if (k == 4) cnt_clr = 1'b0;
            end
            spi_clk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] word);
        cs_low();
        send_bits(word, 31, 0, 1'b0);
        cs_up();
    endtask

    task automatic clear_counts();
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
    endtask

    function automatic logic [CNT_W-1:0] hc(input int ch);
        return hit_cnt[CNT_W*ch +: CNT_W];
    endfunction

    initial begin
        #60000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        spi_cs   = 1'b1;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        cnt_clr  = 1'b0;
        pls_len  = PLS_W'(16);
        // ch0: PRG_EXECUTE 0x100..0x1FF; ch1/ch2: READ_STATUS1 full window;
        // ch3: PRG_EXECUTE inverted window; ch4: PRG_EXECUTE full window but disabled
        ch_en     = 5'b01111;
        ch_opcode = {PRG_EXECUTE, PRG_EXECUTE, READ_STATUS1, READ_STATUS1, PRG_EXECUTE};
        ch_low    = {24'h000000, 24'h000200, 24'h000000, 24'h000000, 24'h000100};
        ch_high   = {24'hFFFFFF, 24'h000100, 24'hFFFFFF, 24'hFFFFFF, 24'h0001FF};
        wait_neg(5);
        check("reset_trg_pls", trg_pls, 0);
        check("reset_trg_any", trg_any, 0);
        check("reset_hit_cnt", hit_cnt, 0);
        rst = 1'b0;
        wait_neg(4);

        // In-window address
        mon_reset();
        send_frame(32'h10000180);
        wait_neg(40);
        check("a_latency", first_hi[0] - rise_cyc, 4);
        check("a_width", n_hi[0], 16);
        check("a_contig", last_hi[0] - first_hi[0] + 1, 16);
        check("a_others_pls", n_hi[1] + n_hi[2] + n_hi[3] + n_hi[4], 0);
        check("a_hit0", hc(0), 1);
        check("a_hit_others", hit_cnt[NCH*CNT_W-1:CNT_W], 0);

        // One above HIGH, then exactly LOW
        mon_reset();
        send_frame(32'h10000200);
        wait_neg(40);
        check("b_above_high_pls", n_hi[0], 0);
        check("b_above_high_cnt", hc(0), 1);
        mon_reset();
        send_frame(32'h10000100);
        wait_neg(40);
        check("c_eq_low_pls", n_hi[0], 16);
        check("c_eq_low_cnt", hc(0), 2);

        clear_counts();
        check("clr_all", hit_cnt, 0);

        // Duplicate opcodes fire together
        mon_reset();
        send_frame(32'h0F0000A0);
        wait_neg(40);
        check("d_ch1_lat", first_hi[1] - rise_cyc, 4);
        check("d_ch2_lat", first_hi[2] - rise_cyc, 4);
        check("d_ch1_width", n_hi[1], 16);
        check("d_ch2_width", n_hi[2], 16);
        check("d_any_width", n_any, 16);
        check("d_ch0_pls", n_hi[0], 0);
        check("d_hit1", hc(1), 1);
        check("d_hit2", hc(2), 1);

        // Truncated frame: 20 bits then deselect
        mon_reset();
        cs_low();
        send_bits(32'h10000180, 31, 12, 1'b0);
        cs_up();
        wait_neg(40);
        check("e_short_pls", n_hi[0], 0);
        check("e_short_cnt", hc(0), 0);

        // Zero pulse length stretches to one cycle
        pls_len = '0;
        mon_reset();
        send_frame(32'h10000180);
        wait_neg(40);
        check("f_len0_width", n_hi[0], 1);
        check("f_len0_cnt", hc(0), 1);

        // Retrigger while the first pulse is still active
        pls_len = PLS_W'(400);
        clear_counts();
        mon_reset();
        send_frame(32'h10000180);
        r1 = rise_cyc;
        send_frame(32'h10000180);
        r2 = rise_cyc;
        wait_neg(450);
        check("g_start", first_hi[0] - r1, 4);
        check("g_end", last_hi[0] - r2, 403);
        check("g_contig", n_hi[0], (r2 + 403) - (r1 + 4) + 1);
        check("g_cnt", hc(0), 2);

        // Saturation at all-ones after five hits total
        pls_len = PLS_W'(4);
        for (int n = 0; n < 3; n++) send_frame(32'h10000180);
        wait_neg(20);
        check("h_saturate", hc(0), 3);

        // Clear coinciding with a hit leaves the count at one
        cs_low();
        send_bits(32'h10000180, 31, 0, 1'b1);
        cs_up();
        wait_neg(20);
        check("i_clr_and_hit", hc(0), 1);

        // Reset mid-frame; CS stays low through it so the remainder is not a frame
        mon_reset();
        cs_low();
        send_bits(32'h10000180, 31, 16, 1'b0);
        rst = 1'b1;
        wait_neg(3);
        check("j_rst_pls", trg_pls, 0);
        check("j_rst_any", trg_any, 0);
        check("j_rst_cnt", hit_cnt, 0);
        rst = 1'b0;
        wait_neg(2);
        send_bits(32'h10000180, 15, 0, 1'b0);
        cs_up();
        wait_neg(40);
        check("j_after_pls", n_hi[0], 0);
        check("j_after_cnt", hc(0), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
